// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ERROR = 3'd4
    } fetch_state_t;

    // Next-PC select encodings
    localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
    localparam logic [1:0] PCSEL_TARGET = 2'b01;
    localparam logic [1:0] PCSEL_ALU    = 2'b10;

    // Error cause codes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    // addi x0, x0, 0 -- what decode sees before any real fetch completes
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_watchdog.sv
// Response timeout counter: cleared while a request is being issued,
// counts while waiting, flags expiry on its last permitted cycle.
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Wait-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is only meaningful while counting
    always_comb begin
        expire = enable && (count == LAST);
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: issues one request at a time at the PC,
// holds the returned instruction for decode, steers the PC update and
// halts permanently on a misaligned PC or a lost memory response.
module fetch_controller #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        ResetN,
    input  logic [31:0] PC,
    output logic        PCWrite,
    output logic [1:0]  PCSel,
    input  logic        RedirectValid,
    input  logic [1:0]  RedirectSrc,
    output logic        IReqValid,
    output logic [31:0] IReqAddr,
    input  logic        IReqReady,
    input  logic        IRespValid,
    input  logic [31:0] IRespData,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    input  logic        InstrReady,
    output logic        FetchError,
    output logic [1:0]  ErrCause
);

    import fetch_pkg::*;

    fetch_state_t state, state_next;
    logic         kill, kill_next;
    logic [1:0]   err_next;
    logic [31:0]  req_addr;
    logic         aligned;
    logic         accept;
    logic         resp_take;
    logic         wd_clear, wd_enable, wd_expire;

    assign aligned   = (PC[1:0] == 2'b00);
    assign accept    = (state == ST_REQ) && aligned && IReqReady;
    // A response is only kept if it belongs to the live instruction stream
    assign resp_take = (state == ST_WAIT) && IRespValid && !kill && !RedirectValid;
    assign IReqAddr  = PC;
    assign FetchError = (state == ST_ERROR);

    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (CLK),
        .rst_n  (ResetN),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // Control state: FSM state, kill flag and sticky error cause
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state    <= ST_IDLE;
            kill     <= 1'b0;
            ErrCause <= ERR_NONE;
        end else begin
            state    <= state_next;
            kill     <= kill_next;
            ErrCause <= err_next;
        end
    end

    // Held instruction and its PC, visible to decode
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            Instr   <= NOP_INSTR;
            InstrPC <= '0;
        end else if (resp_take) begin
            Instr   <= IRespData;
            InstrPC <= req_addr;
        end
    end

    // Address of the outstanding request, needed to tag its response
    always_ff @(posedge CLK) begin
        if (accept) begin
            req_addr <= PC;
        end
    end

    // Next-state, kill and error-cause decisions
    always_comb begin
        state_next = state;
        kill_next  = kill;
        err_next   = ErrCause;
        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (!aligned) begin
                    state_next = ST_ERROR;
                    err_next   = ERR_MISALIGN;
                end else if (IReqReady) begin
                    state_next = ST_WAIT;
                    // request already left at the stale PC
                    kill_next  = RedirectValid;
                end
            end
            ST_WAIT: begin
                if (IRespValid) begin
                    kill_next  = 1'b0;
                    state_next = (kill || RedirectValid) ? ST_REQ : ST_HOLD;
                end else if (wd_expire) begin
                    state_next = ST_ERROR;
                    err_next   = ERR_TIMEOUT;
                end else if (RedirectValid) begin
                    kill_next  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (RedirectValid || InstrReady) begin
                    state_next = ST_REQ;
                end
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Handshake, PC steering and watchdog control
    always_comb begin
        IReqValid  = 1'b0;
        InstrValid = 1'b0;
        PCWrite    = 1'b0;
        PCSel      = PCSEL_PLUS4;
        wd_clear   = 1'b0;
        wd_enable  = 1'b0;
        case (state)
            ST_REQ: begin
                IReqValid = aligned;
                wd_clear  = 1'b1;
            end
            ST_WAIT: wd_enable = 1'b1;
            ST_HOLD: InstrValid = !RedirectValid;
            default: ;
        endcase
        if (RedirectValid && (state != ST_ERROR)) begin
            PCWrite = 1'b1;
            PCSel   = RedirectSrc;
        end else if (InstrValid && InstrReady) begin
            PCWrite = 1'b1;
            PCSel   = PCSEL_PLUS4;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: acts as program counter, instruction memory
// and decode, and checks the handed-off instruction stream against a
// program-order model of the PC.
module tb_fetch_controller;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        ResetN;
    logic [31:0] PC;
    logic        PCWrite;
    logic [1:0]  PCSel;
    logic        RedirectValid;
    logic [1:0]  RedirectSrc;
    logic        IReqValid;
    logic [31:0] IReqAddr;
    logic        IReqReady;
    logic        IRespValid;
    logic [31:0] IRespData;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrReady;
    logic        FetchError;
    logic [1:0]  ErrCause;

    fetch_controller #(.TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .ResetN(ResetN), .PC(PC), .PCWrite(PCWrite), .PCSel(PCSel),
        .RedirectValid(RedirectValid), .RedirectSrc(RedirectSrc),
        .IReqValid(IReqValid), .IReqAddr(IReqAddr), .IReqReady(IReqReady),
        .IRespValid(IRespValid), .IRespData(IRespData),
        .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC),
        .InstrReady(InstrReady), .FetchError(FetchError), .ErrCause(ErrCause)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;
    bit          outstanding;
    int          resp_cnt;
    logic [31:0] out_addr;
    bit          exp_err;
    logic [31:0] acc_q[$];
    logic [31:0] hand_q[$];
    int          cyc;
    int          first_hand_cyc;
    logic        obs_ireq, obs_ivalid;
    logic [31:0] obs_instr, obs_instr_pc;

    // Memory image: distinct, non-NOP word per address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], 16'h0} ^ (a * 32'h0000_9E37) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] hand_at(input int i);
        return (i < hand_q.size()) ? hand_q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc_q.size()) ? acc_q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        PC = '0; RedirectValid = 1'b0; RedirectSrc = 2'b01; IReqReady = 1'b0;
        IRespValid = 1'b0; IRespData = '0; InstrReady = 1'b0;
        model_pc = '0; outstanding = 0; resp_cnt = 0; out_addr = '0; exp_err = 0;
        acc_q.delete(); hand_q.delete(); cyc = 0; first_hand_cyc = -1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ireq_valid", IReqValid, 0);
        chk("rst_instr_valid", InstrValid, 0);
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_instr", Instr, NOP);
        chk("rst_instr_pc", InstrPC, 0);
        chk("rst_fetch_error", FetchError, 0);
        chk("rst_err_cause", ErrCause, 0);
        ResetN = 1'b1;
    endtask

    // One clock cycle: drive environment, check outputs, advance the model
    task automatic run_cycle(input bit redir, input logic [1:0] src, input logic [31:0] tgt,
                             input bit req_rdy, input bit dec_rdy, input int lat);
        bit handoff;
        @(posedge CLK);
        #1;
        PC = model_pc;
        RedirectValid = redir;
        RedirectSrc = src;
        IReqReady = req_rdy;
        InstrReady = dec_rdy;
        if (outstanding && resp_cnt == 0) begin
            IRespValid = 1'b1;
            IRespData = mem(out_addr);
        end else begin
            IRespValid = 1'b0;
            IRespData = $urandom;
        end
        #1;
        obs_ireq = IReqValid; obs_ivalid = InstrValid;
        obs_instr = Instr; obs_instr_pc = InstrPC;
        handoff = InstrValid && InstrReady;
        chk("fetch_error", FetchError, exp_err);
        if (exp_err) begin
            chk("err_ireq_valid", IReqValid, 0);
            chk("err_instr_valid", InstrValid, 0);
            chk("err_pcwrite", PCWrite, 0);
        end else begin
            if (IReqValid) chk("req_addr", IReqAddr, model_pc);
            if (outstanding) chk("one_outstanding", IReqValid, 0);
            if (redir) begin
                chk("redir_mask", InstrValid, 0);
                chk("redir_pcwrite", PCWrite, 1);
                chk("redir_pcsel", PCSel, src);
            end else if (handoff) begin
                chk("hand_instr_pc", InstrPC, model_pc);
                chk("hand_instr", Instr, mem(model_pc));
                chk("hand_pcwrite", PCWrite, 1);
                chk("hand_pcsel", PCSel, 2'b00);
                if (hand_q.size() == 0) first_hand_cyc = cyc;
                hand_q.push_back(InstrPC);
            end else begin
                chk("idle_pcwrite", PCWrite, 0);
                chk("idle_pcsel", PCSel, 2'b00);
            end
        end
        if (outstanding) begin
            if (IRespValid) outstanding = 0;
            else resp_cnt--;
        end
        if (IReqValid && IReqReady) begin
            outstanding = 1;
            out_addr = model_pc;
            resp_cnt = lat;
            acc_q.push_back(model_pc);
        end
        if (!exp_err) model_pc = redir ? tgt : (handoff ? model_pc + 32'd4 : model_pc);
        cyc++;
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 2'b01, 32'h0, 1, 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] tmp;

        // Sequential fetch, one-cycle memory latency
        do_reset();
        plain(9);
        chk("seq_count", hand_q.size(), 3);
        chk("seq_pc0", hand_at(0), 32'h0);
        chk("seq_pc1", hand_at(1), 32'h4);
        chk("seq_pc2", hand_at(2), 32'h8);
        chk("seq_req2", acc_at(2), 32'h8);
        chk("seq_latency", first_hand_cyc, 2);

        // Redirect while waiting on 0x4: its response must be discarded
        do_reset();
        plain(3);
        run_cycle(0, 2'b01, 32'h0, 1, 1, 1);
        run_cycle(1, 2'b01, 32'h40, 1, 1, 0);
        plain(5);
        chk("wait_redir_count", hand_q.size(), 2);
        chk("wait_redir_hand1", hand_at(1), 32'h40);
        chk("wait_redir_req1", acc_at(1), 32'h4);
        chk("wait_redir_req2", acc_at(2), 32'h40);

        // Redirect in HOLD with decode ready the same cycle
        do_reset();
        plain(2);
        run_cycle(1, 2'b10, 32'h80, 1, 1, 0);
        chk("hold_redir_nohand", hand_q.size(), 0);
        plain(3);
        chk("hold_redir_count", hand_q.size(), 1);
        chk("hold_redir_hand", hand_at(0), 32'h80);

        // Decode backpressure for five cycles
        do_reset();
        plain(2);
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, 2'b01, 32'h0, 1, 0, 0);
            chk("bp_valid", obs_ivalid, 1);
            chk("bp_instr", obs_instr, mem(32'h0));
            chk("bp_instr_pc", obs_instr_pc, 32'h0);
            chk("bp_no_req", obs_ireq, 0);
        end
        plain(2);
        chk("bp_hand_count", hand_q.size(), 1);
        chk("bp_req_count", acc_q.size(), 2);
        chk("bp_next_req", acc_at(1), 32'h4);

        // Misaligned PC: no request, sticky error, redirects ignored
        do_reset();
        model_pc = 32'h6;
        plain(1);
        chk("mis_no_req", obs_ireq, 0);
        exp_err = 1;
        for (int i = 0; i < 4; i++) run_cycle(1, 2'b01, 32'h100, 1, 1, 0);
        chk("mis_cause", ErrCause, 2'b01);
        chk("mis_req_count", acc_q.size(), 0);

        // Response never arrives: error after eight wait cycles
        do_reset();
        run_cycle(0, 2'b01, 32'h0, 1, 1, 1000);
        plain(8);
        chk("to_cause_early", ErrCause, 2'b00);
        exp_err = 1;
        plain(2);
        chk("to_cause", ErrCause, 2'b10);

        // Asynchronous reset in the middle of a wait
        do_reset();
        plain(3);
        run_cycle(0, 2'b01, 32'h0, 1, 1, 1000);
        plain(3);
        chk("mid_pre_instr", Instr, mem(32'h0));
        #2;
        ResetN = 1'b0;
        #1;
        chk("mid_ireq_valid", IReqValid, 0);
        chk("mid_instr_valid", InstrValid, 0);
        chk("mid_pcwrite", PCWrite, 0);
        chk("mid_instr", Instr, NOP);
        chk("mid_instr_pc", InstrPC, 0);
        chk("mid_fetch_error", FetchError, 0);
        chk("mid_err_cause", ErrCause, 0);

        // Randomized traffic against the program-order model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tmp = $urandom;
            tgt = {16'h0, tmp[15:2], 2'b00};
            run_cycle($urandom_range(0, 5) == 0,
                      ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10,
                      tgt,
                      $urandom_range(0, 2) != 0,
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3));
        end
        chk("rand_liveness", hand_q.size() >= 30, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch around the program counter.
- Issues instruction-memory requests at the current PC and hands fetched instructions to decode through a valid/ready interface.
- Drives the PC write-enable and next-PC select, applying redirects (branch/jump) ahead of sequential advance.
- Flags misaligned fetches and memory-response timeouts, then halts fetch until reset.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT without a response before a timeout error is raised (≥2).

Ports:
- CLK  input  1  clock; all state changes on rising edge
- ResetN  input  1  asynchronous, active-low reset
- PC  input  32  current PC from program counter
- PCWrite  output  1  PC register update enable this cycle
- PCSel  output  2  next-PC select: 00 PC+4, 01 PCTarget, 10 ALUResult; 00 whenever PCWrite=0
- RedirectValid  input  1  single-cycle redirect pulse from execute
- RedirectSrc  input  2  01 PCTarget or 10 ALUResult; other codes are not permitted
- IReqValid  output  1  fetch request
- IReqAddr  output  32  fetch address; equal to PC
- IReqReady  input  1  memory accepts request
- IRespValid  input  1  response data valid
- IRespData  input  32  fetched instruction
- InstrValid  output  1  instruction to decode valid
- Instr  output  32  held instruction
- InstrPC  output  32  PC of held instruction
- InstrReady  input  1  decode accepts instruction
- FetchError  output  1  sticky error
- ErrCause  output  2  00 none, 01 misaligned, 10 timeout

Behaviour:
- Reset values (ResetN low, asynchronous):
  - State IDLE, Kill=0, timeout counter 0.
  - Instr=0x00000013, InstrPC=0, FetchError=0, ErrCause=00.
  - Combinational outputs in IDLE: IReqValid=0, InstrValid=0, PCWrite=0.
- States: IDLE, REQ, WAIT, HOLD, ERROR.
- IDLE: go to REQ after one cycle.
- REQ:
  - IReqValid=1 while PC[1:0]==00.
  - If PC[1:0]!=00: no request is issued; go to ERROR with ErrCause=01.
  - IReqReady=1: go to WAIT and clear the counter.
  - IReqAddr tracks PC. It changes while IReqValid is high only after a redirect, and memory samples it only when IReqReady=1.
- WAIT:
  - Counter increments each cycle.
  - IRespValid=1 with Kill=0 and no redirect: capture IRespData→Instr and the request address→InstrPC; go to HOLD.
  - IRespValid=1 with Kill=1, or in the same cycle as a redirect: discard the response, clear Kill, go to REQ.
  - Counter reaches TIMEOUT_CYCLES-1 with no response: go to ERROR with ErrCause=10.
- HOLD:
  - InstrValid = ~RedirectValid; a redirect masks the handoff combinationally.
  - InstrValid & InstrReady: PCWrite=1, PCSel=00; go to REQ.
- Redirects (RedirectValid=1) in IDLE, REQ, WAIT or HOLD:
  - PCWrite=1 and PCSel=RedirectSrc; redirect has priority over the sequential advance.
  - REQ with IReqReady=1: go to WAIT with Kill=1.
  - REQ without IReqReady: stay in REQ; the new PC is presented next cycle.
  - WAIT: set Kill, or discard the response if one arrives in the same cycle.
  - HOLD: drop the held instruction; go to REQ.
  - Repeated redirects while in WAIT each update the PC; Kill stays set.
- ERROR:
  - Terminal until reset; FetchError=1.
  - IReqValid, InstrValid and PCWrite all 0; redirects are ignored.
- Latency: request accepted at cycle t, response at t+k, InstrValid at t+k+1; the PC advances on the handoff edge.
- Invariants: at most one outstanding request; no instruction reaches decode from a request issued before a redirect.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum;
  - PCSel encodings PCSEL_PLUS4 / PCSEL_TARGET / PCSEL_ALU;
  - ErrCause codes;
  - NOP constant 32'h00000013.
- Optional sub-module fetch_watchdog: the timeout counter with clear, enable and expire.

Test Plan:
- Sequential fetch: PC=0, 1-cycle response latency, InstrReady=1 → requests at 0x0, 0x4, 0x8; InstrPC matches each; PCSel=00 on each handoff.
- Redirect during WAIT: RedirectValid with RedirectSrc=01 while waiting on 0x4 → PCWrite=1, PCSel=01; the 0x4 response is discarded (InstrValid stays 0); the next request goes to the new PC.
- Redirect in HOLD with InstrReady=1 the same cycle → InstrValid=0 that cycle; no sequential PCWrite; PCSel=01 or 10 per RedirectSrc.
- Decode backpressure: InstrReady=0 for 5 cycles → Instr/InstrPC stable, no new request, no PCWrite; release → single handoff.
- Misaligned: PC=0x6 in REQ → IReqValid never asserted; FetchError=1, ErrCause=01; redirects ignored.
- Timeout with TIMEOUT_CYCLES=8 and no response → ERROR after 8 WAIT cycles, ErrCause=10; asserting ResetN low mid-WAIT returns all outputs to reset values immediately.
